// File: rtl/sa_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sa_fifo_pkg
// Shared constants and types for the 32x16 systolic-array operand FIFO.
//   SA_FIFO_DEPTH / _AW / _DW / _CW : depth, pointer, data and count widths
//   sa_fifo_ptr_t / _cnt_t / _data_t : pointer, occupancy and payload types
//   sa_fifo_head_e                   : head-presentation state
// -----------------------------------------------------------------------------
package sa_fifo_pkg;

    localparam int unsigned SA_FIFO_DEPTH = 32;
    localparam int unsigned SA_FIFO_AW    = 5;
    localparam int unsigned SA_FIFO_DW    = 16;
    localparam int unsigned SA_FIFO_CW    = 6;

    typedef logic [SA_FIFO_AW-1:0] sa_fifo_ptr_t;
    typedef logic [SA_FIFO_CW-1:0] sa_fifo_cnt_t;
    typedef logic [SA_FIFO_DW-1:0] sa_fifo_data_t;

    // ST_EMPTY: nothing on rd_data; ST_HEAD: RAM dout holds the head entry.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HEAD  = 1'b1
    } sa_fifo_head_e;

endpackage

// File: rtl/sa_fifo_32x16_ctrl_if.sv
// -----------------------------------------------------------------------------
// sa_fifo_32x16_ctrl_if
// Valid/ready handshake bundle between the FIFO and its producer/consumer.
//   wr_valid/wr_ready/wr_data : write side handshake and payload
//   wr_afull                  : registered almost-full flag
//   rd_valid/rd_ready/rd_data : read side handshake and head entry
//   count                     : registered total occupancy 0..32
// Modports: master = producer/consumer side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface sa_fifo_32x16_ctrl_if;
    import sa_fifo_pkg::*;

    logic          wr_valid;
    logic          wr_ready;
    sa_fifo_data_t wr_data;
    logic          wr_afull;
    logic          rd_valid;
    logic          rd_ready;
    sa_fifo_data_t rd_data;
    sa_fifo_cnt_t  count;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, wr_afull, rd_valid, rd_data, count
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, wr_afull, rd_valid, rd_data, count
    );

endinterface

// File: rtl/sa_ram_rws_32x16.sv
// -----------------------------------------------------------------------------
// sa_ram_rws_32x16
// Behavioural model of the 32x16 two-port RAM macro: synchronous write,
// registered read address (loaded when i_re=1), combinational dout from the
// latched address, giving one cycle of read latency.
//   clk            : clock
//   i_we/i_wa/i_di : write enable, address, data
//   i_re/i_ra      : read-address load enable and address
//   o_dout         : contents at the latched read address
//   i_pwrbus_ram_pd: macro power-down bus (no effect in this model)
// -----------------------------------------------------------------------------
module sa_ram_rws_32x16
    import sa_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          i_we,
    input  sa_fifo_ptr_t  i_wa,
    input  sa_fifo_data_t i_di,
    input  logic          i_re,
    input  sa_fifo_ptr_t  i_ra,
    output sa_fifo_data_t o_dout,
    input  logic [31:0]   i_pwrbus_ram_pd
);

    sa_fifo_data_t r_mem [SA_FIFO_DEPTH];
    sa_fifo_ptr_t  r_ra;
    logic          w_unused_pd;

    // NOTE: the array and read-address latch have no reset; a RAM macro cannot
    // clear its contents, and the controller never presents unfetched data.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wa] <= i_di;
        if (i_re) r_ra <= i_ra;
    end

    // A write and an address load to the same entry on one edge both land,
    // so dout shows the freshly written word the following cycle.
    assign o_dout      = r_mem[r_ra];
    assign w_unused_pd = ^i_pwrbus_ram_pd;

endmodule

// File: rtl/sa_fifo_32x16_ctrl.sv
// -----------------------------------------------------------------------------
// sa_fifo_32x16_ctrl
// 32-entry x 16-bit FIFO controller sequencing sa_ram_rws_32x16. Owns the
// write/read pointers, occupancy count and a one-deep read prefetch so the
// head entry sits on rd_data whenever rd_valid is high.
//   clk           : rising-edge clock
//   rstn          : synchronous active-low reset
//   fifo_if       : slave side of the write/read handshake bundle
//   pwrbus_ram_pd : passed unchanged to the RAM macro
// Parameter AFULL_LVL (1..32): occupancy at/above which wr_afull asserts.
// -----------------------------------------------------------------------------
module sa_fifo_32x16_ctrl
    import sa_fifo_pkg::*;
#(
    parameter int unsigned AFULL_LVL = 28
) (
    input  logic                 clk,
    input  logic                 rstn,
    sa_fifo_32x16_ctrl_if.slave  fifo_if,
    input  logic [31:0]          pwrbus_ram_pd
);

    localparam sa_fifo_cnt_t FULL_CNT  = sa_fifo_cnt_t'(SA_FIFO_DEPTH);
    localparam sa_fifo_cnt_t AFULL_CNT = sa_fifo_cnt_t'(AFULL_LVL);

    sa_fifo_head_e r_state;
    sa_fifo_ptr_t  r_wr_ptr;
    sa_fifo_ptr_t  r_rd_ptr;
    sa_fifo_cnt_t  r_count;
    sa_fifo_cnt_t  r_pend;       // written but not yet fetched into the head
    logic          r_wr_ready;
    logic          r_afull;

    sa_fifo_head_e w_state_nxt;
    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_fetch;
    sa_fifo_cnt_t  w_count_nxt;
    sa_fifo_cnt_t  w_pend_nxt;
    sa_fifo_data_t w_ram_dout;

    // Handshakes are masked while rstn is low so the RAM is not written and
    // no transfer is implied during a reset cycle.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_wr_fire   = 1'b0;
        w_rd_fire   = 1'b0;
        w_fetch     = 1'b0;
        w_state_nxt = r_state;

        w_wr_fire = rstn && fifo_if.wr_valid && r_wr_ready;
        w_rd_fire = rstn && fifo_if.rd_ready && (r_state == ST_HEAD);

        // Refill the head when it is empty or being consumed, from either a
        // pending entry or the word being written this very cycle.
        w_fetch = ((r_state == ST_EMPTY) || w_rd_fire) &&
                  ((r_pend != '0) || w_wr_fire);

        case (r_state)
            ST_EMPTY: if (w_fetch)                w_state_nxt = ST_HEAD;
            ST_HEAD:  if (w_rd_fire && !w_fetch)  w_state_nxt = ST_EMPTY;
            default:                              w_state_nxt = ST_EMPTY;
        endcase
    end

    assign w_count_nxt = r_count + sa_fifo_cnt_t'(w_wr_fire) - sa_fifo_cnt_t'(w_rd_fire);
    assign w_pend_nxt  = r_pend  + sa_fifo_cnt_t'(w_wr_fire) - sa_fifo_cnt_t'(w_fetch);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_EMPTY;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_wr_ready <= 1'b0;
            r_afull    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_pend     <= w_pend_nxt;
            // Full is looked up from the next count, so a read at full only
            // reopens the write side one cycle later.
            r_wr_ready <= (w_count_nxt != FULL_CNT);
            r_afull    <= (w_count_nxt >= AFULL_CNT);
            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + sa_fifo_ptr_t'(1);
            if (w_fetch)   r_rd_ptr <= r_rd_ptr + sa_fifo_ptr_t'(1);
        end
    end

    // Without a fetch the RAM read address holds, keeping rd_data stable.
    sa_ram_rws_32x16 u_ram (
        .clk             (clk),
        .i_we            (w_wr_fire),
        .i_wa            (r_wr_ptr),
        .i_di            (fifo_if.wr_data),
        .i_re            (w_fetch),
        .i_ra            (r_rd_ptr),
        .o_dout          (w_ram_dout),
        .i_pwrbus_ram_pd (pwrbus_ram_pd)
    );

    assign fifo_if.wr_ready = r_wr_ready;
    assign fifo_if.wr_afull = r_afull;
    assign fifo_if.rd_valid = (r_state == ST_HEAD);
    assign fifo_if.rd_data  = w_ram_dout;
    assign fifo_if.count    = r_count;

endmodule

// File: tb/tb_sa_fifo_32x16_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sa_fifo_32x16_ctrl
// Self-checking bench for sa_fifo_32x16_ctrl. A queue holds the expected
// contents; occupancy, handshake flags and head data are derived from it.
// -----------------------------------------------------------------------------
module tb_sa_fifo_32x16_ctrl;

    localparam int AFULL_LVL = 28;
    localparam int DEPTH     = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pwrbus_ram_pd = 32'h0;

    sa_fifo_32x16_ctrl_if u_if ();

    sa_fifo_32x16_ctrl #(.AFULL_LVL(AFULL_LVL)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .fifo_if       (u_if),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] q [$];
    bit          m_wr_ready = 1'b0;
    bit          m_afull    = 1'b0;
    int          n_pushed   = 0;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("count",    32'(u_if.count),    32'(q.size()));
        check("wr_ready", 32'(u_if.wr_ready), 32'(m_wr_ready));
        check("rd_valid", 32'(u_if.rd_valid), 32'(q.size() != 0));
        check("wr_afull", 32'(u_if.wr_afull), 32'(m_afull));
        if (q.size() != 0)
            check("rd_data", 32'(u_if.rd_data), 32'(q[0]));
    endtask

    // One clock: drive inputs, predict the transfers, advance the model at the
    // edge, then compare on the falling edge.
    task automatic step(input logic rn, input logic wv, input logic [15:0] wd, input logic rr);
        bit wf;
        bit rf;
        rstn          = rn;
        u_if.wr_valid = wv;
        u_if.wr_data  = wd;
        u_if.rd_ready = rr;
        wf = rn && wv && m_wr_ready;
        rf = rn && rr && (q.size() != 0);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_wr_ready = 1'b0;
            m_afull    = 1'b0;
        end else begin
            if (rf) void'(q.pop_front());
            if (wf) begin
                q.push_back(wd);
                n_pushed++;
            end
            m_wr_ready = (q.size() != DEPTH);
            m_afull    = (q.size() >= AFULL_LVL);
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int guard;
        logic [15:0] stale_word;

        // Reset, with handshakes offered that must be ignored
        phase = "reset";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234, 1'b1);
        // wr_ready is still low in the first cycle after release
        step(1'b1, 1'b1, 16'hDEAD, 1'b0);

        phase = "single";
        step(1'b1, 1'b1, 16'hA5A5, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b0);

        // Fill 0..31, offer a 33rd word, then read+write at full
        phase = "fill";
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 16'(i), 1'b0);
        step(1'b1, 1'b1, 16'hBEEF, 1'b0);
        phase = "full_rw";
        step(1'b1, 1'b1, 16'hBEEF, 1'b1);
        phase = "drain";
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Stall with writes continuing behind a frozen head
        phase = "stall";
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
        phase = "stall_drain";
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Streaming near occupancy 3 with random consumer backpressure
        phase = "wrap";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
        n_pushed = 0;
        guard    = 0;
        while (n_pushed < 100 && guard < 1000) begin
            logic rr;
            rr = 1'($urandom);
            step(1'b1, (q.size() <= 3) || rr, 16'($urandom), rr);
            guard++;
        end
        check("wrap_budget", 32'(n_pushed >= 100), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Reset in the middle of a busy stream
        phase = "mid_reset";
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 16'(16'hC000 + i), 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b1);
        step(1'b1, 1'b1, 16'hEEEE, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        phase = "recover";
        stale_word = 16'h5A5A;
        step(1'b1, 1'b1, stale_word, 1'b0);
        step(1'b1, 1'b1, 16'h0F0F, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
